mimo_channel_encoder: RTL

MIMO_CHANNEL_ENCODER -- requirements
Module: mimo_channel_encoder

---
 rtl/mimo_channel_encoder.sv | 128 ++++++++++++
 1 files changed

// File: rtl/mimo_channel_encoder.sv
// 8x8 MIMO channel model: Gray-PAM4 maps X_i to symbols and forms Y = H*s one column per cycle.
// Optional macro Y_SAT_EN selects a saturating output conversion instead of two's-complement wrap.
`ifndef WL
`define WL 16
`endif

module mimo_channel_encoder (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [15:0]         X_i,
    input  logic [64*`WL-1:0]   Hmatrix_i,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*`WL-1:0]    Yarray_o,
    output logic [64*`WL-1:0]   Hmatrix_o,
    output logic [15:0]         Xref_o
);
    localparam int W  = `WL;
    localparam int PW = W + 2;
    localparam int AW = W + 5;

    // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t state, state_next;

    logic [2:0]              cnt;
    logic [15:0]             x_r;
    logic [64*W-1:0]         h_r;
    logic [8*W-1:0]          y_r;
    logic signed [AW-1:0]    acc      [8];
    logic signed [AW-1:0]    acc_next [8];
    logic signed [W-1:0]     h_col    [8];
    logic signed [PW-1:0]    h_ext    [8];
    logic signed [PW-1:0]    h_three  [8];
    logic signed [PW-1:0]    prod     [8];
    logic [W-1:0]            y_conv   [8];
    logic [1:0]              sym;

    localparam logic signed [AW-1:0] MAX_A = {{6{1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [AW-1:0] MIN_A = {{6{1'b1}}, {(W-1){1'b0}}};

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_next = MAC;
            end
            MAC: begin
                if (cnt == 3'd7) state_next = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Product H*s is built from +-H and +-3H = +-(2H + H): no multiplier needed.
    always_comb begin
        sym = x_r[2*cnt +: 2];
        for (int r = 0; r < 8; r++) begin
            h_col[r]   = h_r[(r*8 + int'(cnt))*W +: W];
            h_ext[r]   = {{2{h_col[r][W-1]}}, h_col[r]};
            h_three[r] = (h_ext[r] <<< 1) + h_ext[r];
            case (sym)
                2'b00:   prod[r] = -h_three[r];
                2'b01:   prod[r] = -h_ext[r];
                2'b11:   prod[r] = h_ext[r];
                default: prod[r] = h_three[r];
            endcase
            acc_next[r] = acc[r] + {{(AW-PW){prod[r][PW-1]}}, prod[r]};
`ifdef Y_SAT_EN
            if (acc_next[r] > MAX_A)
                y_conv[r] = {1'b0, {(W-1){1'b1}}};
            else if (acc_next[r] < MIN_A)
                y_conv[r] = {1'b1, {(W-1){1'b0}}};
            else
                y_conv[r] = acc_next[r][W-1:0];
`else
            y_conv[r] = acc_next[r][W-1:0];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
            cnt   <= '0;
            x_r   <= '0;
            h_r   <= '0;
            y_r   <= '0;
            for (int r = 0; r < 8; r++) acc[r] <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        x_r <= X_i;
                        h_r <= Hmatrix_i;
                        cnt <= '0;
                        for (int r = 0; r < 8; r++) acc[r] <= '0;
                    end
                end
                MAC: begin
                    cnt <= cnt + 3'd1;
                    for (int r = 0; r < 8; r++) acc[r] <= acc_next[r];
                    // Result register is written only on the last column.
                    if (cnt == 3'd7) begin
                        for (int r = 0; r < 8; r++) y_r[r*W +: W] <= y_conv[r];
                    end
                end
                default: ;
            endcase
        end
    end

    assign Yarray_o  = y_r;
    assign Hmatrix_o = h_r;
    assign Xref_o    = x_r;

endmodule
